// File: rtl/x74138_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : x74138_rr_arbiter_pkg
//  Brief    : Shared decoder-enable codes and arbiter state encoding.
//  Revision : 1.0
// ============================================================================
package x74138_rr_arbiter_pkg;

    // Enable bus is {G1, G2A_n, G2B_n}
    localparam logic [2:0] DEC_EN_ON  = 3'b100;
    localparam logic [2:0] DEC_EN_OFF = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GUARD = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/x74138.sv
`default_nettype none
// ============================================================================
//  Module   : x74138
//  Brief    : 3-to-8 line decoder with active-low outputs (74HC138 behaviour).
//  Revision : 1.0
// ============================================================================
module x74138 (
    input  logic       g1,
    input  logic       g2a_n,
    input  logic       g2b_n,
    input  logic [2:0] a,
    output logic [7:0] y_n
);

    logic w_enabled;

    assign w_enabled = g1 & ~g2a_n & ~g2b_n;
    assign y_n       = w_enabled ? ~(8'h01 << a) : 8'hFF;

endmodule
`default_nettype wire

// File: rtl/x74138_rr_arbiter_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick8
//  Brief    : Round-robin picker; first set request after 'last', wrapping.
//  Revision : 1.0
// ============================================================================
module rr_pick8 (
    input  logic [7:0] req,
    input  logic [2:0] last,
    output logic       any,
    output logic [2:0] idx
);

    logic [2:0] w_cand;

    always_comb begin
        any    = 1'b0;
        idx    = last;
        w_cand = last;
        for (int i = 1; i <= 8; i++) begin
            w_cand = last + 3'(i);
            if (!any && req[w_cand]) begin
                any = 1'b1;
                idx = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/x74138_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : x74138_rr_arbiter
//  Brief    : 8-way round-robin arbiter driving a x74138 decoder for grants.
//  Revision : 1.0
// ============================================================================
module x74138_rr_arbiter
    import x74138_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int GUARD    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [2:0] dec_en,
    output logic [2:0] dec_sel,
    output logic [7:0] gnt_n,
    output logic       gnt_valid,
    output logic [2:0] gnt_id,
    output logic       timeout
);

    localparam int HOLD_W  = $clog2(MAX_HOLD + 1);
    localparam int GUARD_W = $clog2(GUARD + 1);
    localparam logic [HOLD_W-1:0]  C_HOLD_MAX  = HOLD_W'(MAX_HOLD);
    localparam logic [GUARD_W-1:0] C_GUARD_MAX = GUARD_W'(GUARD);

    arb_state_t          r_state;
    logic [2:0]          r_last;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [GUARD_W-1:0]  r_guard_cnt;
    logic                w_pick_any;
    logic [2:0]          w_pick_idx;

    rr_pick8 u_pick (
        .req  (req),
        .last (r_last),
        .any  (w_pick_any),
        .idx  (w_pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_last      <= 3'd7;
            r_hold_cnt  <= '0;
            r_guard_cnt <= '0;
            dec_en      <= DEC_EN_OFF;
            dec_sel     <= 3'd0;
            gnt_valid   <= 1'b0;
            gnt_id      <= 3'd0;
            timeout     <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_any) begin
                        r_state    <= ST_GRANT;
                        dec_en     <= DEC_EN_ON;
                        dec_sel    <= w_pick_idx;
                        gnt_id     <= w_pick_idx;
                        gnt_valid  <= 1'b1;
                        r_hold_cnt <= HOLD_W'(1);
                    end
                end
                ST_GRANT: begin
                    // A release coinciding with the hold limit is not a timeout
                    if (!req[gnt_id] || (r_hold_cnt == C_HOLD_MAX)) begin
                        r_state     <= ST_GUARD;
                        dec_en      <= DEC_EN_OFF;
                        gnt_valid   <= 1'b0;
                        r_last      <= gnt_id;
                        r_guard_cnt <= GUARD_W'(1);
                        timeout     <= req[gnt_id];
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                    end
                end
                ST_GUARD: begin
                    if (r_guard_cnt == C_GUARD_MAX) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_guard_cnt <= r_guard_cnt + GUARD_W'(1);
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    dec_en    <= DEC_EN_OFF;
                    gnt_valid <= 1'b0;
                end
            endcase
        end
    end

    x74138 u_dec (
        .g1    (dec_en[2]),
        .g2a_n (dec_en[1]),
        .g2b_n (dec_en[0]),
        .a     (dec_sel),
        .y_n   (gnt_n)
    );

endmodule
`default_nettype wire
